// File: rtl/axi_chk_pkg.sv
// Shared error-code map and helpers for the AXI4 protocol checker.
// One err_vec_t bit per check; the bit index is also the reported error code.
package axi_chk_pkg;

  localparam int ERR_W = 12;

  localparam int ERR_STABLE_AW  = 0;
  localparam int ERR_STABLE_W   = 1;
  localparam int ERR_STABLE_B   = 2;
  localparam int ERR_STABLE_AR  = 3;
  localparam int ERR_STABLE_R   = 4;
  localparam int ERR_VALID_DROP = 5;
  localparam int ERR_WLAST_LEN  = 6;
  localparam int ERR_B_ORPHAN   = 7;
  localparam int ERR_R_ORPHAN   = 8;
  localparam int ERR_OVERFLOW   = 9;
  localparam int ERR_TIMEOUT    = 10;
  localparam int ERR_XVALID     = 11;

  typedef logic [ERR_W-1:0] err_vec_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_set(input err_vec_t v);
    logic [3:0] r;
    r = '0;
    for (int i = ERR_W - 1; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_chk_fifo.sv
// Small synchronous FIFO holding burst lengths / beat counts for the WLAST check.
// Registered empty/full; a push while full is ignored unless a pop frees a slot in the same cycle.
module axi_chk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/axi_protocol_checker.sv
// Passive AXI4 monitor: stability, drop, burst-length, orphan, overflow, timeout and X checks.
// Flags register one edge after the violating sample; never drives the bus, so it applies no backpressure.
module axi_protocol_checker
  import axi_chk_pkg::*;
#(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [LEN_WIDTH-1:0]    awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [LEN_WIDTH-1:0]    arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  input  logic                    rready,
  input  logic                    clr_err,
  output logic [ERR_W-1:0]        err_sticky,
  output logic                    err_pulse,
  output logic [3:0]              first_err,
  output logic                    first_err_vld,
  output logic [OW-1:0]           wr_outstanding,
  output logic [OW-1:0]           rd_outstanding
);

  localparam int AX_PW = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 3 + 2;
  localparam int W_PW  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int B_PW  = ID_WIDTH + 2;
  localparam int R_PW  = ID_WIDTH + DATA_WIDTH + 2 + 1;
  localparam int BW    = LEN_WIDTH + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  // Channel index order: 0=AW 1=W 2=B 3=AR 4=R
  logic [4:0] vld, rdy, hs;
  logic [4:0] vld_q, rdy_q;

  logic [AX_PW-1:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
  logic [W_PW-1:0]  w_pl, w_pl_q;
  logic [B_PW-1:0]  b_pl, b_pl_q;
  logic [R_PW-1:0]  r_pl, r_pl_q;

  logic [TW-1:0] wait_q [5];
  logic [TW-1:0] wait_d [5];
  logic          timeout_hit;

  logic [BW-1:0] w_beat_q, w_beat_d, beat_inc;
  logic [OW-1:0] wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [OW-1:0] wr_done_q, wr_done_d;
  logic          w_push, beat_overrun, pair_pop, len_mismatch;

  logic [LEN_WIDTH-1:0] aw_len_head;
  logic [BW-1:0]        w_cnt_head;
  logic                 aw_full, aw_empty, w_full, w_empty;

  logic                 x_seen;
  err_vec_t             err_now;
  err_vec_t             err_sticky_q, err_sticky_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [3:0]           first_err_q, first_err_d;
  logic                 first_err_vld_q, first_err_vld_d;

  assign vld = {rvalid, arvalid, bvalid, wvalid, awvalid};
  assign rdy = {rready, arready, bready, wready, awready};
  assign hs  = vld & rdy;

  assign aw_pl = {awid, awaddr, awlen, awsize, awburst};
  assign ar_pl = {arid, araddr, arlen, arsize, arburst};
  assign w_pl  = {wdata, wstrb, wlast};
  assign b_pl  = {bid, bresp};
  assign r_pl  = {rid, rdata, rresp, rlast};

  axi_chk_fifo #(.WIDTH(LEN_WIDTH), .DEPTH(MAX_OUTSTANDING)) aw_len_fifo (
    .clk(clk), .rst(rst), .push(hs[0]), .pop(pair_pop), .din(awlen),
    .dout(aw_len_head), .full(aw_full), .empty(aw_empty)
  );

  axi_chk_fifo #(.WIDTH(BW), .DEPTH(MAX_OUTSTANDING)) w_cnt_fifo (
    .clk(clk), .rst(rst), .push(w_push), .pop(pair_pop), .din(beat_inc),
    .dout(w_cnt_head), .full(w_full), .empty(w_empty)
  );

`ifdef SYNTHESIS
  assign x_seen = 1'b0;
`else
  assign x_seen = $isunknown({vld, rdy});
`endif

  // W data may lead AW, so lengths and beat counts are paired only once both heads exist.
  always_comb begin
    w_beat_d     = w_beat_q;
    w_push       = 1'b0;
    beat_overrun = 1'b0;
    beat_inc     = w_beat_q + BW'(1);
    if (hs[1]) begin
      if (wlast) begin
        w_push   = 1'b1;
        w_beat_d = '0;
      end else if (beat_inc == BW'(2 ** LEN_WIDTH)) begin
        beat_overrun = 1'b1;
        w_beat_d     = '0;
      end else begin
        w_beat_d = beat_inc;
      end
    end
    pair_pop     = !aw_empty && !w_empty;
    len_mismatch = pair_pop && (w_cnt_head != (BW'(aw_len_head) + BW'(1)));

    wr_done_d = wr_done_q;
    if (pair_pop && !hs[2]) begin
      if (wr_done_q != OW'(MAX_OUTSTANDING)) wr_done_d = wr_done_q + OW'(1);
    end else if (hs[2] && !pair_pop) begin
      if (wr_done_q != '0) wr_done_d = wr_done_q - OW'(1);
    end

    wr_out_d = wr_out_q;
    if (hs[0] && !hs[2]) begin
      if (wr_out_q != OW'(MAX_OUTSTANDING)) wr_out_d = wr_out_q + OW'(1);
    end else if (hs[2] && !hs[0]) begin
      if (wr_out_q != '0) wr_out_d = wr_out_q - OW'(1);
    end

    rd_out_d = rd_out_q;
    if (hs[3] && !(hs[4] && rlast)) begin
      if (rd_out_q != OW'(MAX_OUTSTANDING)) rd_out_d = rd_out_q + OW'(1);
    end else if (hs[4] && rlast && !hs[3]) begin
      if (rd_out_q != '0) rd_out_d = rd_out_q - OW'(1);
    end
  end

  // Wait counters stop at the limit so a stalled transfer reports exactly once.
  always_comb begin
    wait_d      = wait_q;
    timeout_hit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (!vld[c] || rdy[c]) begin
        wait_d[c] = '0;
      end else if (wait_q[c] != TW'(TIMEOUT_CYCLES)) begin
        wait_d[c] = wait_q[c] + TW'(1);
        if (wait_q[c] == TW'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
      end
    end
  end

  always_comb begin
    err_now                 = '0;
    err_now[ERR_STABLE_AW]  = vld_q[0] && !rdy_q[0] && (aw_pl != aw_pl_q);
    err_now[ERR_STABLE_W]   = vld_q[1] && !rdy_q[1] && (w_pl != w_pl_q);
    err_now[ERR_STABLE_B]   = vld_q[2] && !rdy_q[2] && (b_pl != b_pl_q);
    err_now[ERR_STABLE_AR]  = vld_q[3] && !rdy_q[3] && (ar_pl != ar_pl_q);
    err_now[ERR_STABLE_R]   = vld_q[4] && !rdy_q[4] && (r_pl != r_pl_q);
    err_now[ERR_VALID_DROP] = |(vld_q & ~rdy_q & ~vld);
    err_now[ERR_WLAST_LEN]  = len_mismatch || beat_overrun;
    err_now[ERR_B_ORPHAN]   = hs[2] && (wr_done_q == '0);
    err_now[ERR_R_ORPHAN]   = hs[4] && (rd_out_q == '0);
    err_now[ERR_OVERFLOW]   = (hs[0] && (wr_out_q == OW'(MAX_OUTSTANDING)))
                            || (hs[3] && (rd_out_q == OW'(MAX_OUTSTANDING)))
                            || (hs[0] && aw_full && !pair_pop)
                            || (w_push && w_full && !pair_pop);
    err_now[ERR_TIMEOUT]    = timeout_hit;
    err_now[ERR_XVALID]     = x_seen;

    err_pulse_d     = |err_now;
    err_sticky_d    = err_sticky_q | err_now;
    first_err_d     = first_err_q;
    first_err_vld_d = first_err_vld_q;
    // A clear that coincides with a fresh violation restarts from that violation alone.
    if (clr_err) begin
      err_sticky_d    = err_now;
      first_err_d     = (|err_now) ? lowest_set(err_now) : 4'd0;
      first_err_vld_d = |err_now;
    end else if (!first_err_vld_q && (|err_now)) begin
      first_err_d     = lowest_set(err_now);
      first_err_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q           <= '0;
      rdy_q           <= '0;
      aw_pl_q         <= '0;
      w_pl_q          <= '0;
      b_pl_q          <= '0;
      ar_pl_q         <= '0;
      r_pl_q          <= '0;
      wait_q          <= '{default: '0};
      w_beat_q        <= '0;
      wr_out_q        <= '0;
      rd_out_q        <= '0;
      wr_done_q       <= '0;
      err_sticky_q    <= '0;
      err_pulse_q     <= 1'b0;
      first_err_q     <= '0;
      first_err_vld_q <= 1'b0;
    end else begin
      vld_q           <= vld;
      rdy_q           <= rdy;
      aw_pl_q         <= aw_pl;
      w_pl_q          <= w_pl;
      b_pl_q          <= b_pl;
      ar_pl_q         <= ar_pl;
      r_pl_q          <= r_pl;
      wait_q          <= wait_d;
      w_beat_q        <= w_beat_d;
      wr_out_q        <= wr_out_d;
      rd_out_q        <= rd_out_d;
      wr_done_q       <= wr_done_d;
      err_sticky_q    <= err_sticky_d;
      err_pulse_q     <= err_pulse_d;
      first_err_q     <= first_err_d;
      first_err_vld_q <= first_err_vld_d;
    end
  end

  assign err_sticky     = err_sticky_q;
  assign err_pulse      = err_pulse_q;
  assign first_err      = first_err_q;
  assign first_err_vld  = first_err_vld_q;
  assign wr_outstanding = wr_out_q;
  assign rd_outstanding = rd_out_q;

endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed bench for axi_protocol_checker; each scenario task checks its own hand-computed results.
module tb_axi_protocol_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready, clr_err;
  logic [11:0] err_sticky;
  logic        err_pulse, first_err_vld;
  logic [3:0]  first_err, wr_outstanding, rd_outstanding;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  axi_protocol_checker dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .clr_err(clr_err),
    .err_sticky(err_sticky), .err_pulse(err_pulse), .first_err(first_err),
    .first_err_vld(first_err_vld), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_inputs();
    awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'd1; awvalid = 0; awready = 0;
    wdata = 0; wstrb = 4'hF; wlast = 0; wvalid = 0; wready = 0;
    bid = 0; bresp = 0; bvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'd1; arvalid = 0; arready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0; rready = 0;
    clr_err = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    step();
  endtask

  task automatic aw_hs(input logic [7:0] len, input logic [31:0] addr);
    awaddr = addr; awlen = len; awvalid = 1; awready = 1;
    step();
    awvalid = 0; awready = 0;
  endtask

  task automatic ar_hs(input logic [7:0] len, input logic [31:0] addr);
    araddr = addr; arlen = len; arvalid = 1; arready = 1;
    step();
    arvalid = 0; arready = 0;
  endtask

  task automatic w_beats(input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      wdata = 32'hA000 + i; wlast = (i == last_idx); wvalid = 1; wready = 1;
      step();
    end
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic r_beats(input int n);
    for (int i = 0; i < n; i++) begin
      rdata = 32'hB000 + i; rlast = (i == n - 1); rvalid = 1; rready = 1;
      step();
    end
    rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic b_hs();
    bvalid = 1; bready = 1;
    step();
    bvalid = 0; bready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (err_sticky !== 12'h000) begin n_miss++; $display("FAIL reset_sticky got=%h exp=000", err_sticky); end
    n_vec++; if (err_pulse !== 1'b0) begin n_miss++; $display("FAIL reset_pulse got=%b exp=0", err_pulse); end
    n_vec++; if (first_err !== 4'd0 || first_err_vld !== 1'b0) begin n_miss++; $display("FAIL reset_first got=%0d/%b exp=0/0", first_err, first_err_vld); end
    n_vec++; if (wr_outstanding !== 4'd0 || rd_outstanding !== 4'd0) begin n_miss++; $display("FAIL reset_outstanding got=%0d/%0d exp=0/0", wr_outstanding, rd_outstanding); end
  endtask

  task automatic test_legal_traffic();
    do_reset();
    aw_hs(8'd3, 32'h1000);
    n_vec++; if (wr_outstanding !== 4'd1) begin n_miss++; $display("FAIL legal_wr_out_after_aw got=%0d exp=1", wr_outstanding); end
    w_beats(4, 3);
    idle(3);
    b_hs();
    ar_hs(8'd1, 32'h2000);
    n_vec++; if (rd_outstanding !== 4'd1) begin n_miss++; $display("FAIL legal_rd_out_after_ar got=%0d exp=1", rd_outstanding); end
    r_beats(2);
    idle(2);
    n_vec++; if (err_sticky !== 12'h000) begin n_miss++; $display("FAIL legal_sticky got=%h exp=000", err_sticky); end
    n_vec++; if (wr_outstanding !== 4'd0 || rd_outstanding !== 4'd0) begin n_miss++; $display("FAIL legal_outstanding got=%0d/%0d exp=0/0", wr_outstanding, rd_outstanding); end
    n_vec++; if (first_err_vld !== 1'b0) begin n_miss++; $display("FAIL legal_first_vld got=%b exp=0", first_err_vld); end
  endtask

  task automatic test_stable_aw();
    do_reset();
    awaddr = 32'h100; awvalid = 1; awready = 0;
    step();
    n_vec++; if (err_sticky !== 12'h000) begin n_miss++; $display("FAIL stable_aw_before got=%h exp=000", err_sticky); end
    awaddr = 32'h104;
    step();
    n_vec++; if (err_sticky !== 12'h001) begin n_miss++; $display("FAIL stable_aw_sticky got=%h exp=001", err_sticky); end
    n_vec++; if (first_err !== 4'd0 || first_err_vld !== 1'b1) begin n_miss++; $display("FAIL stable_aw_first got=%0d/%b exp=0/1", first_err, first_err_vld); end
    n_vec++; if (err_pulse !== 1'b1) begin n_miss++; $display("FAIL stable_aw_pulse_hi got=%b exp=1", err_pulse); end
    step();
    n_vec++; if (err_pulse !== 1'b0) begin n_miss++; $display("FAIL stable_aw_pulse_lo got=%b exp=0", err_pulse); end
    awready = 1;
    step();
    awvalid = 0; awready = 0;
  endtask

  task automatic test_wlast_len();
    do_reset();
    aw_hs(8'd3, 32'h300);
    w_beats(3, 2);
    idle(3);
    n_vec++; if (err_sticky !== 12'h040) begin n_miss++; $display("FAIL wlast_short_sticky got=%h exp=040", err_sticky); end
    n_vec++; if (first_err !== 4'd6) begin n_miss++; $display("FAIL wlast_short_first got=%0d exp=6", first_err); end
    do_reset();
    w_beats(4, 3);
    idle(5);
    aw_hs(8'd3, 32'h400);
    idle(3);
    n_vec++; if (err_sticky !== 12'h000) begin n_miss++; $display("FAIL w_leads_aw_sticky got=%h exp=000", err_sticky); end
  endtask

  task automatic test_orphan_overflow();
    do_reset();
    b_hs();
    n_vec++; if (err_sticky !== 12'h080) begin n_miss++; $display("FAIL b_orphan_sticky got=%h exp=080", err_sticky); end
    n_vec++; if (first_err !== 4'd7 || wr_outstanding !== 4'd0) begin n_miss++; $display("FAIL b_orphan_first got=%0d/%0d exp=7/0", first_err, wr_outstanding); end
    arvalid = 1; arready = 1;
    for (int i = 0; i < 8; i++) begin
      araddr = 32'h1000 * i;
      step();
    end
    n_vec++; if (rd_outstanding !== 4'd8 || err_sticky[9] !== 1'b0) begin n_miss++; $display("FAIL ar_at_limit got=%0d/%b exp=8/0", rd_outstanding, err_sticky[9]); end
    araddr = 32'h9000;
    step();
    arvalid = 0; arready = 0;
    n_vec++; if (err_sticky !== 12'h280) begin n_miss++; $display("FAIL ar_overflow_sticky got=%h exp=280", err_sticky); end
    n_vec++; if (rd_outstanding !== 4'd8 || first_err !== 4'd7) begin n_miss++; $display("FAIL ar_overflow_sat got=%0d/%0d exp=8/7", rd_outstanding, first_err); end
  endtask

  task automatic test_timeout_clear();
    int pulses;
    do_reset();
    pulses = 0;
    araddr = 32'h40; arlen = 8'd0; arvalid = 1; arready = 0;
    for (int i = 0; i < 1023; i++) begin
      step();
      if (err_pulse === 1'b1) pulses++;
    end
    n_vec++; if (err_sticky[10] !== 1'b0) begin n_miss++; $display("FAIL timeout_early got=%b exp=0", err_sticky[10]); end
    step();
    if (err_pulse === 1'b1) pulses++;
    n_vec++; if (err_sticky !== 12'h400 || first_err !== 4'd10) begin n_miss++; $display("FAIL timeout_hit got=%h/%0d exp=400/10", err_sticky, first_err); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (err_pulse === 1'b1) pulses++;
    end
    n_vec++; if (pulses !== 1) begin n_miss++; $display("FAIL timeout_once got=%0d exp=1", pulses); end
    arready = 1;
    step();
    arvalid = 0; arready = 0;
    rdata = 32'hA; rlast = 1; rvalid = 1; rready = 0;
    step();
    rdata = 32'hB; clr_err = 1;
    step();
    clr_err = 0;
    n_vec++; if (err_sticky !== 12'h010) begin n_miss++; $display("FAIL clr_new_sticky got=%h exp=010", err_sticky); end
    n_vec++; if (first_err !== 4'd4 || first_err_vld !== 1'b1 || err_pulse !== 1'b1) begin n_miss++; $display("FAIL clr_new_first got=%0d/%b/%b exp=4/1/1", first_err, first_err_vld, err_pulse); end
    rready = 1;
    step();
    rvalid = 0; rready = 0; rlast = 0;
    step();
    n_vec++; if (rd_outstanding !== 4'd0 || err_sticky !== 12'h010) begin n_miss++; $display("FAIL clr_after_r got=%0d/%h exp=0/010", rd_outstanding, err_sticky); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    aw_hs(8'd3, 32'h500);
    wdata = 32'h1; wlast = 0; wvalid = 1; wready = 1;
    idle(2);
    n_vec++; if (wr_outstanding !== 4'd1) begin n_miss++; $display("FAIL midburst_before got=%0d exp=1", wr_outstanding); end
    clear_inputs();
    rst = 1'b1;
    #1;
    n_vec++; if (wr_outstanding !== 4'd0 || err_sticky !== 12'h000 || first_err_vld !== 1'b0) begin n_miss++; $display("FAIL midburst_async got=%0d/%h/%b exp=0/000/0", wr_outstanding, err_sticky, first_err_vld); end
    step();
    rst = 1'b0;
    step();
    aw_hs(8'd3, 32'h600);
    w_beats(4, 3);
    idle(3);
    b_hs();
    idle(2);
    n_vec++; if (err_sticky !== 12'h000 || wr_outstanding !== 4'd0) begin n_miss++; $display("FAIL midburst_after got=%h/%0d exp=000/0", err_sticky, wr_outstanding); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_legal_traffic();
    test_stable_aw();
    test_wlast_len();
    test_orphan_overflow();
    test_timeout_clear();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
